pulse_injector: RTL

Synthetic-pulse transmitter for the PUEO single-channel trigger path. It sits between the ADC sample stream and `matched_filter`. On command, it adds a scaled, phase-shifted copy of the template pulse onto the live 8-sample SSR stream. The template is the time-reverse of the matched-filter coefficients, so the downstream filter responds with its full autocorrelation peak. It is used for in-situ trigger calibration and for loopback verification of the filter.

---
 rtl/pulse_injector_if.sv | 24 ++
 rtl/pulse_injector.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pulse_injector_if.sv
// Sample-stream and pulse-command bundle between the ADC path, pulse_injector and the filter.
interface pulse_injector_if #(
    parameter int unsigned NBITS  = 12,
    parameter int unsigned NSAMPS = 8
);
    logic [NBITS*NSAMPS-1:0] data_i;
    logic                    inject_i;
    logic [2:0]              offset_i;
    logic [3:0]              amp_i;
    logic [NBITS*NSAMPS-1:0] data_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    dropped_o;

    modport master (
        output data_i, inject_i, offset_i, amp_i,
        input  data_o, busy_o, done_o, dropped_o
    );

    modport slave (
        input  data_i, inject_i, offset_i, amp_i,
        output data_o, busy_o, done_o, dropped_o
    );
endinterface

// File: rtl/pulse_injector.sv
// Adds a scaled, phase-shifted copy of the time-reversed matched-filter template
// onto the live SSR sample stream; two register stages from data_i to data_o.
module pulse_injector #(
    parameter int unsigned NBITS  = 12,
    parameter int unsigned NSAMPS = 8
) (
    input  logic            aclk,
    input  logic            aclk_rst,
    pulse_injector_if.slave bus
);
    localparam int unsigned DW        = NBITS * NSAMPS;
    localparam int unsigned PW        = 7;
    localparam int unsigned SW        = NBITS + 1;
    localparam int unsigned TLEN      = 42;
    localparam int unsigned LAST_BEAT = 6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    localparam logic signed [3:0] TMPL [TLEN] = '{
         4'sd1,  4'sd1, -4'sd1, -4'sd2,  4'sd1,  4'sd4,  4'sd1, -4'sd4,
        -4'sd4,  4'sd0,  4'sd4,  4'sd2,  4'sd0, -4'sd2, -4'sd2, -4'sd1,
         4'sd0,  4'sd1,  4'sd2,  4'sd1,  4'sd0, -4'sd1, -4'sd1, -4'sd1,
         4'sd0,  4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd0, -4'sd1, -4'sd1,
        -4'sd1,  4'sd0,  4'sd0,  4'sd1,  4'sd1,  4'sd0,  4'sd0,  4'sd0,
        -4'sd1, -4'sd1
    };

    logic [0:0]       state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       offset_q, offset_d;
    logic [3:0]       amp_q, amp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dropped_q, dropped_d;
    logic [DW-1:0]    s1_data_q, s1_data_d;
    logic [PW*NSAMPS-1:0] s1_p_q, s1_p_d;
    logic [DW-1:0]    data_q, data_d;

    logic [6:0]              tidx;
    logic signed [3:0]       tap;
    logic signed [PW-1:0]    tap_x;
    logic signed [PW-1:0]    amp_x;
    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    sum;
    logic [NBITS-1:0]        sat;

    // Playout control: accept in IDLE, walk seven beats in PLAY.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        offset_d  = offset_q;
        amp_d     = amp_q;
        done_d    = 1'b0;
        dropped_d = dropped_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.inject_i) begin
                    state_d  = ST_PLAY;
                    k_d      = 3'd0;
                    offset_d = bus.offset_i;
                    amp_d    = bus.amp_i;
                end
            end
            ST_PLAY: begin
                if (bus.inject_i) begin
                    dropped_d = 1'b1;
                end
                if (k_q == 3'(LAST_BEAT)) begin
                    state_d = ST_IDLE;
                    k_d     = 3'd0;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_PLAY);
    end

    // Stage-1 inputs: pulse block for the current beat; out-of-range taps wrap above TLEN.
    always_comb begin
        s1_data_d = bus.data_i;
        s1_p_d    = '0;
        tidx      = '0;
        tap       = '0;
        tap_x     = '0;
        amp_x     = PW'($signed({1'b0, amp_q}));
        prod      = '0;
        for (int i = 0; i < NSAMPS; i++) begin
            tidx = 7'(k_q) * 7'(NSAMPS) + 7'(i) - 7'(offset_q);
            tap  = '0;
            if (state_q == ST_PLAY && tidx < 7'(TLEN)) begin
                tap = TMPL[tidx[5:0]];
            end
            tap_x = PW'(tap);
            prod  = amp_x * tap_x;
            s1_p_d[PW*i +: PW] = prod;
        end
    end

    // Stage-2 inputs: widened sum clamped to the signed sample range.
    always_comb begin
        data_d = '0;
        sum    = '0;
        sat    = '0;
        for (int i = 0; i < NSAMPS; i++) begin
            sum = SW'($signed(s1_data_q[NBITS*i +: NBITS])) + SW'($signed(s1_p_q[PW*i +: PW]));
            if (sum[SW-1] != sum[SW-2]) begin
                sat = sum[SW-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
            end else begin
                sat = sum[NBITS-1:0];
            end
            data_d[NBITS*i +: NBITS] = sat;
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            offset_q  <= '0;
            amp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            s1_data_q <= '0;
            s1_p_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            offset_q  <= offset_d;
            amp_q     <= amp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
            s1_data_q <= s1_data_d;
            s1_p_q    <= s1_p_d;
            data_q    <= data_d;
        end
    end

    assign bus.data_o    = data_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.dropped_o = dropped_q;

endmodule
